// File: rtl/bf_mem_arbiter.sv
// rtl/bf_mem_arbiter.sv - two-requester (fetch/execute) arbiter for a single 8-bit memory port
// Optional: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: execute wins ties).
module bf_mem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_ack,
    output logic [DATA_W-1:0] x_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] RL = 4'(READ_LATENCY);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       is_write;
    logic       grant_x;
    logic       any_req;
    logic       rd_done;

    assign any_req = f_req | x_req;
    assign rd_done = (cnt == RL);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, serve whichever side did not own the port last.
    assign grant_x = x_req & (~f_req | ~owner);
`else
    assign grant_x = x_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  if (is_write || rd_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            f_rdata   <= '0;
            x_rdata   <= '0;
            f_ack     <= 1'b0;
            x_ack     <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b0;
            cnt       <= '0;
            is_write  <= 1'b0;
        end else begin
            f_ack <= 1'b0;
            x_ack <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (any_req) begin
                        owner    <= grant_x;
                        mem_addr <= grant_x ? x_addr : f_addr;
                        if (grant_x) mem_wdata <= x_wdata;
                        is_write <= grant_x & x_we;
                        mem_we   <= grant_x & x_we;
                        cnt      <= 4'd1;
                        busy     <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (is_write) begin
                        // Memory has taken the write at this edge; only execute writes.
                        mem_we <= 1'b0;
                        x_ack  <= 1'b1;
                    end else if (rd_done) begin
                        if (owner) begin
                            x_rdata <= mem_rdata;
                            x_ack   <= 1'b1;
                        end else begin
                            f_rdata <= mem_rdata;
                            f_ack   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bf_mem_arbiter.sv
// tb/tb_bf_mem_arbiter.sv - directed self-checking bench for bf_mem_arbiter
module tb_bf_mem_arbiter;

    localparam int RL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       f_req;
    logic [7:0] f_addr;
    logic       f_ack;
    logic [7:0] f_rdata;
    logic       x_req;
    logic       x_we;
    logic [7:0] x_addr;
    logic [7:0] x_wdata;
    logic       x_ack;
    logic [7:0] x_rdata;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       owner;

    logic       mem_init;
    logic [7:0] mem_arr [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bf_mem_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
        .x_ack(x_ack), .x_rdata(x_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    function automatic logic [7:0] init_val(input int a);
        case (a)
            8'h10:   return 8'hA5;
            8'h11:   return 8'h5A;
            8'h30:   return 8'h33;
            8'h31:   return 8'h44;
            8'hFF:   return 8'hC3;
            8'h00:   return 8'h7E;
            default: return 8'(a) ^ 8'h96;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= init_val(i);
        end else if (mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_arr[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1;
        f_req = 1'b0; f_addr = 8'h00; x_req = 1'b0; x_we = 1'b0; x_addr = 8'h00; x_wdata = 8'h00;
        repeat (3) tick();
        mem_init = 1'b0; rst = 1'b0;
        n_checks++; if ({f_ack, x_ack, mem_we, busy, owner} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {f_ack, x_ack, mem_we, busy, owner}); end
        n_checks++; if ({mem_addr, mem_wdata, f_rdata, x_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", {mem_addr, mem_wdata, f_rdata, x_rdata}); end
        repeat (2) tick();
        n_checks++; if ({busy, mem_we, mem_addr} !== 10'h0) begin n_fail++; $display("FAIL idle_hold: got %h want 000", {busy, mem_we, mem_addr}); end
    endtask

    task automatic test_fetch();
        int n;
        f_addr = 8'h10; f_req = 1'b1;
        tick();
        n = 1;
        n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL fetch_addr: got %h want 10", mem_addr); end
        n_checks++; if ({busy, owner, mem_we} !== 3'b100) begin n_fail++; $display("FAIL fetch_grant: got %b want 100", {busy, owner, mem_we}); end
        while (!f_ack && n < 20) begin tick(); n++; end
        n_checks++; if (n !== RL + 1) begin n_fail++; $display("FAIL fetch_latency: got %0d want %0d", n, RL + 1); end
        n_checks++; if (f_rdata !== 8'hA5) begin n_fail++; $display("FAIL fetch_data: got %h want a5", f_rdata); end
        n_checks++; if (x_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_no_xack: got %b want 0", x_ack); end
        f_req = 1'b0;
        tick();
        n_checks++; if ({f_ack, busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b want 00", {f_ack, busy}); end
    endtask

    task automatic test_write_read();
        int n;
        int we_cnt;
        x_addr = 8'h20; x_wdata = 8'h3C; x_we = 1'b1; x_req = 1'b1;
        tick();
        n = 1; we_cnt = 0;
        n_checks++; if ({mem_addr, mem_wdata, owner} !== {8'h20, 8'h3C, 1'b1}) begin n_fail++; $display("FAIL write_issue: got %h %h %b want 20 3c 1", mem_addr, mem_wdata, owner); end
        if (mem_we) we_cnt++;
        while (!x_ack && n < 20) begin tick(); n++; if (mem_we) we_cnt++; end
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL write_latency: got %0d want 2", n); end
        x_req = 1'b0;
        tick();
        if (mem_we) we_cnt++;
        n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL write_we_cycles: got %0d want 1", we_cnt); end
        n_checks++; if (mem_arr[8'h20] !== 8'h3C) begin n_fail++; $display("FAIL write_mem: got %h want 3c", mem_arr[8'h20]); end
        x_we = 1'b0; x_wdata = 8'hEE; x_req = 1'b1;
        tick();
        n = 1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL xread_we: got %b want 0", mem_we); end
        while (!x_ack && n < 20) begin tick(); n++; end
        n_checks++; if (n !== RL + 1) begin n_fail++; $display("FAIL xread_latency: got %0d want %0d", n, RL + 1); end
        n_checks++; if (x_rdata !== 8'h3C) begin n_fail++; $display("FAIL xread_data: got %h want 3c", x_rdata); end
        n_checks++; if (f_rdata !== 8'hA5) begin n_fail++; $display("FAIL xread_frdata_kept: got %h want a5", f_rdata); end
        x_req = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        int n;
        f_addr = 8'h30; x_addr = 8'h31; x_we = 1'b0;
        for (int r = 0; r < 3; r++) begin
            f_req = 1'b1; x_req = 1'b1;
            tick();
            n_checks++; if ({owner, mem_addr} !== {1'b1, 8'h31}) begin n_fail++; $display("FAIL tie_first r%0d: got %b %h want 1 31", r, owner, mem_addr); end
            n = 1;
            while (!x_ack && n < 20) begin tick(); n++; end
            n_checks++; if ({x_ack, f_ack, x_rdata} !== {2'b10, 8'h44}) begin n_fail++; $display("FAIL tie_xdone r%0d: got %b %b %h want 1 0 44", r, x_ack, f_ack, x_rdata); end
            x_req = 1'b0;
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tie_gap r%0d: got %b want 0", r, busy); end
            tick();
            n_checks++; if ({owner, busy, mem_addr} !== {2'b01, 8'h30}) begin n_fail++; $display("FAIL tie_second r%0d: got %b %b %h want 0 1 30", r, owner, busy, mem_addr); end
            n = 1;
            while (!f_ack && n < 20) begin tick(); n++; end
            n_checks++; if ({n, f_rdata} !== {32'(RL + 1), 8'h33}) begin n_fail++; $display("FAIL tie_fdone r%0d: got %0d %h want %0d 33", r, n, f_rdata, RL + 1); end
            f_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_tie_history();
        int n;
        logic exp_first;
`ifdef ARB_ROUND_ROBIN_EN
        exp_first = 1'b0;
`else
        exp_first = 1'b1;
`endif
        x_addr = 8'h31; x_we = 1'b0; x_req = 1'b1;
        tick();
        n = 1;
        while (!x_ack && n < 20) begin tick(); n++; end
        x_req = 1'b0;
        tick();
        n_checks++; if (owner !== 1'b1) begin n_fail++; $display("FAIL hist_owner: got %b want 1", owner); end
        f_addr = 8'h30; f_req = 1'b1; x_req = 1'b1;
        tick();
        n_checks++; if (owner !== exp_first) begin n_fail++; $display("FAIL hist_tie_winner: got %b want %b", owner, exp_first); end
        n = 1;
        while (!(f_ack || x_ack) && n < 20) begin tick(); n++; end
        if (exp_first) x_req = 1'b0; else f_req = 1'b0;
        tick();
        tick();
        n_checks++; if (owner !== ~exp_first) begin n_fail++; $display("FAIL hist_tie_loser: got %b want %b", owner, ~exp_first); end
        n = 1;
        while (!(f_ack || x_ack) && n < 20) begin tick(); n++; end
        f_req = 1'b0; x_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        f_addr = 8'h10; f_req = 1'b1;
        tick();
        tick();
        rst = 1'b1; f_req = 1'b0;
        tick();
        rst = 1'b0;
        n_checks++; if ({f_ack, x_ack, mem_we, busy, owner} !== 5'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got %b want 00000", {f_ack, x_ack, mem_we, busy, owner}); end
        n_checks++; if ({mem_addr, mem_wdata, f_rdata, x_rdata} !== 32'h0) begin n_fail++; $display("FAIL rstmid_data: got %h want 00000000", {mem_addr, mem_wdata, f_rdata, x_rdata}); end
        n = 0;
        repeat (4) begin tick(); if (f_ack) n++; end
        n_checks++; if (n !== 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d want 0", n); end
        f_addr = 8'h11; f_req = 1'b1;
        tick();
        n = 1;
        while (!f_ack && n < 20) begin tick(); n++; end
        n_checks++; if ({n, f_rdata} !== {32'(RL + 1), 8'h5A}) begin n_fail++; $display("FAIL rstmid_fresh: got %0d %h want %0d 5a", n, f_rdata, RL + 1); end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        f_addr = 8'hFF; f_req = 1'b1;
        tick();
        n_checks++; if (mem_addr !== 8'hFF) begin n_fail++; $display("FAIL b2b_addr_ff: got %h want ff", mem_addr); end
        n = 1;
        while (!f_ack && n < 20) begin tick(); n++; end
        n_checks++; if ({n, f_rdata} !== {32'(RL + 1), 8'hC3}) begin n_fail++; $display("FAIL b2b_ff: got %0d %h want %0d c3", n, f_rdata, RL + 1); end
        f_addr = 8'h00;
        tick();
        n_checks++; if ({busy, mem_addr} !== {1'b0, 8'hFF}) begin n_fail++; $display("FAIL b2b_idle_hold: got %b %h want 0 ff", busy, mem_addr); end
        tick();
        n_checks++; if ({busy, mem_addr} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL b2b_addr_00: got %b %h want 1 00", busy, mem_addr); end
        n = 1;
        while (!f_ack && n < 20) begin tick(); n++; end
        n_checks++; if ({n, f_rdata} !== {32'(RL + 1), 8'h7E}) begin n_fail++; $display("FAIL b2b_00: got %0d %h want %0d 7e", n, f_rdata, RL + 1); end
        f_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_tie();
        test_tie_history();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bf_mem_arbiter.md
Name: bf_mem_arbiter

Overview:
- Shares the single 8-bit memory port between two requesters: the instruction fetch unit (read-only) and the execute unit (reads and writes the data cell under the data pointer).
- Sequences each access: arbitration, address issue, fixed read-latency wait, data capture and a one-cycle acknowledge.
- Sits between the CPU control units and the memory; the fetch and execute units stop driving the memory address directly.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- READ_LATENCY, 2, number of clk edges from mem_addr change to valid mem_rdata; legal range 1 to 15.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request; held high until f_ack.
- f_addr  in  ADDR_W  fetch address; stable while f_req is high.
- f_ack  out  1  one-cycle pulse: fetch read complete, f_rdata valid.
- f_rdata  out  DATA_W  fetched byte; holds until the next fetch completion.
- x_req  in  1  execute request; held high until x_ack.
- x_we  in  1  execute write enable (1 = write, 0 = read); stable while x_req is high.
- x_addr  in  ADDR_W  execute address.
- x_wdata  in  DATA_W  execute write data.
- x_ack  out  1  one-cycle pulse: execute access complete.
- x_rdata  out  DATA_W  execute read data; updated only on execute reads.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid READ_LATENCY edges after mem_addr changes.
- busy  out  1  high in ACCESS and DONE.
- owner  out  1  requester being served or last served: 0 = fetch, 1 = execute.

Behaviour:
- Reset values (rst sampled high at an edge):
  - state = IDLE.
  - mem_addr, mem_wdata, f_rdata, x_rdata = 0.
  - mem_we, f_ack, x_ack, busy = 0.
  - owner = 0; counter = 0.
- IDLE:
  - No request: outputs hold; mem_we = 0.
  - Any request: at the edge, select a winner and register mem_addr, mem_wdata and the write flag from that requester. mem_we is set to 1 only for an execute write. Load counter = 1, set owner, go to ACCESS.
- Arbitration: fixed priority, execute before fetch. A losing request stays pending and is granted in the IDLE cycle after the winner's DONE.
- ACCESS, write:
  - mem_we is high for exactly this one cycle; memory captures the write at the edge ending ACCESS.
  - At that edge mem_we is cleared and the state goes to DONE.
- ACCESS, read:
  - mem_we stays 0.
  - Each edge: if counter == READ_LATENCY, capture mem_rdata into the owner's rdata register and go to DONE; otherwise increment counter.
- DONE:
  - The owner's ack is high for this single cycle; no arbitration happens here.
  - Next edge: ack is cleared and the state returns to IDLE.
  - The requester drops req at that edge. If req is still high in IDLE, it is treated as a new request.
- Latency from the request-sampling edge to the ack cycle:
  - Read: READ_LATENCY + 1 cycles.
  - Write: 2 cycles.
- Stable outputs:
  - mem_addr holds its value outside ACCESS.
  - The non-owner's rdata and ack are never touched.
- Boundary cases:
  - Request changes while busy: ignored; values were latched at grant.
  - Requests arriving in DONE: wait for IDLE.
  - Reset mid-ACCESS: access aborted, no ack issued, mem_we = 0 from the next cycle. A partially completed write is not rolled back.
  - Address 0xFF: no wrap or special handling; the address is passed through unchanged.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the requester that was not the most recent owner. After reset owner = 0, so the first tie goes to execute. A single request is granted regardless of history.
- Undefined: fixed priority, execute before fetch, on every tie.

Test Plan:
- Single fetch read, READ_LATENCY=2, f_addr=0x10, memory[0x10]=0xA5 -> mem_addr=0x10 in the cycle after the request edge; f_ack pulses one cycle, 3 cycles after the request edge; f_rdata=0xA5; x_ack stays 0.
- Execute write x_addr=0x20, x_wdata=0x3C, then execute read of 0x20 -> mem_we high for exactly 1 cycle; x_ack 2 cycles after the request; the read returns x_rdata=0x3C; f_rdata unchanged.
- f_req and x_req raised in the same cycle, macro undefined, repeated 3 times -> execute always served first; fetch acked after it; no overlap of busy periods.
- Same tie stimulus with ARB_ROUND_ROBIN_EN -> grant order alternates: execute, fetch, execute, fetch.
- rst asserted during ACCESS of a fetch read -> no f_ack; all outputs at reset values the next cycle; a fresh request afterwards completes normally.
- READ_LATENCY=1, back-to-back fetches to 0xFF and 0x00 -> each acks 2 cycles after its request edge with correct data; no address wrap artefacts.
